// File: rtl/axis_rr_arbiter_if.sv
// Bundle of the N-source AXI-Stream fan-in and the single master output of axis_rr_arbiter.
// slave = arbiter view of the bundle, master = view of the sources/sink around it.
interface axis_rr_arbiter_if #(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int USER_WIDTH = 4,
    parameter int ID_WIDTH   = $clog2(N_SRC)
);
    logic [N_SRC-1:0]            s_tvalid;
    logic [N_SRC-1:0]            s_tready;
    logic [N_SRC*DATA_WIDTH-1:0] s_tdata;
    logic [N_SRC-1:0]            s_tlast;
    logic [N_SRC*USER_WIDTH-1:0] s_tuser;
    logic                        m_tvalid;
    logic                        m_tready;
    logic [DATA_WIDTH-1:0]       m_tdata;
    logic                        m_tlast;
    logic [USER_WIDTH-1:0]       m_tuser;
    logic [ID_WIDTH-1:0]         m_tid;
    logic [DATA_WIDTH/8-1:0]     m_tkeep;

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, s_tuser, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast, m_tuser, m_tid, m_tkeep
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast, s_tuser, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast, m_tuser, m_tid, m_tkeep
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter: N_SRC sources share one master port, grant held until TLAST.
// Optional completed-packet counter output pkt_cnt is enabled by defining AXIS_ARB_PKTCNT_EN.
module axis_rr_arbiter #(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int USER_WIDTH = 4,
    parameter int ID_WIDTH   = $clog2(N_SRC)
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    axis_rr_arbiter_if.slave   bus
`ifdef AXIS_ARB_PKTCNT_EN
    ,
    output logic [15:0]        pkt_cnt
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] grant;
    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] next_ptr;
    logic                rst_meta;
    logic                rst_n_sync;
    logic                busy;
    logic                sel_valid;
    logic                sel_last;
    logic                eop;

    logic [DATA_WIDTH-1:0] src_data [N_SRC];
    logic [USER_WIDTH-1:0] src_user [N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign src_data[i] = bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign src_user[i] = bus.s_tuser[i*USER_WIDTH +: USER_WIDTH];
    end

    // Reset asserts immediately, deasserts two ACLK edges after ARESETn rises.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rst_meta   <= 1'b0;
            rst_n_sync <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_n_sync <= rst_meta;
        end
    end

    // First requester found when scanning start, start+1, ... modulo N_SRC.
    function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                                     input logic [ID_WIDTH-1:0] start);
        logic [ID_WIDTH-1:0] pick;
        logic [ID_WIDTH-1:0] cand;
        pick = start;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand = ID_WIDTH'((int'(start) + k) % N_SRC);
            if (req[cand]) pick = cand;
        end
        return pick;
    endfunction

    assign busy      = (state == BUSY);
    assign sel_valid = bus.s_tvalid[grant];
    assign sel_last  = bus.s_tlast[grant];
    assign eop       = busy & sel_valid & bus.m_tready & sel_last;
    assign next_ptr  = (int'(grant) == N_SRC - 1) ? '0 : grant + ID_WIDTH'(1);

    always_ff @(posedge ACLK or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.s_tvalid) begin
                        grant <= rr_pick(bus.s_tvalid, ptr);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (eop) begin
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Zero-latency pass-through of the granted source; everything is 0 outside BUSY.
    always_comb begin
        bus.m_tvalid = 1'b0;
        bus.m_tdata  = '0;
        bus.m_tlast  = 1'b0;
        bus.m_tuser  = '0;
        bus.m_tid    = '0;
        bus.m_tkeep  = '0;
        bus.s_tready = '0;
        if (busy) begin
            bus.m_tvalid        = sel_valid;
            bus.m_tdata         = src_data[grant];
            bus.m_tlast         = sel_last;
            bus.m_tuser         = src_user[grant];
            bus.m_tid           = grant;
            bus.m_tkeep         = {(DATA_WIDTH/8){sel_valid}};
            bus.s_tready[grant] = bus.m_tready;
        end
    end

`ifdef AXIS_ARB_PKTCNT_EN
    logic [15:0] pkt_cnt_q;

    always_ff @(posedge ACLK or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            pkt_cnt_q <= '0;
        end else if (eop) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-source packet drivers, per-cycle output log, hand-derived expectations.
module tb_axis_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int UW = 4;
    localparam int IW = 2;

    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    axis_rr_arbiter_if #(.N_SRC(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .ID_WIDTH(IW)) bus();

`ifdef AXIS_ARB_PKTCNT_EN
    logic [15:0] pkt_cnt;
    logic [15:0] cnt0;
`endif

    axis_rr_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .ID_WIDTH(IW)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
`ifdef AXIS_ARB_PKTCNT_EN
        ,
        .pkt_cnt (pkt_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    int          pkts_left [N];
    int          beat      [N];
    int          pkt       [N];
    int          plen      [N];
    logic [15:0] base      [N];
    logic [31:0] rdy_pat;
    int          cyc;

    logic          lv    [32];
    logic          llast [32];
    logic          lmr   [32];
    logic [IW-1:0] lid   [32];
    logic [DW-1:0] ldat  [32];
    logic [UW-1:0] lusr  [32];
    logic [N-1:0]  lrdy  [32];
    logic [1:0]    lkeep [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] src_word(input int i, input int p, input int b);
        return 16'(int'(base[i]) + 'h1111 * b + 'h10 * p);
    endfunction

    function automatic logic [UW-1:0] usr_word(input int i, input int b);
        return UW'(i * 4 + b);
    endfunction

    task automatic drive();
        logic [N-1:0]    v;
        logic [N-1:0]    l;
        logic [N*DW-1:0] d;
        logic [N*UW-1:0] u;
        v = '0; l = '0; d = '0; u = '0;
        for (int i = 0; i < N; i++) begin
            if (pkts_left[i] > 0)       v |= N'(1) << i;
            if (beat[i] == plen[i] - 1) l |= N'(1) << i;
            d |= (N*DW)'(src_word(i, pkt[i], beat[i])) << (i * DW);
            u |= (N*UW)'(usr_word(i, beat[i])) << (i * UW);
        end
        bus.s_tvalid = v;
        bus.s_tlast  = l;
        bus.s_tdata  = d;
        bus.s_tuser  = u;
        bus.m_tready = rdy_pat[cyc[4:0]];
    endtask

    task automatic start();
        cyc = 0;
        drive();
    endtask

    // Log outputs mid-cycle, then advance any source whose beat is accepted on the next edge.
    task automatic step();
        logic [N-1:0] hs;
        @(negedge ACLK);
        lv[cyc]    = bus.m_tvalid;
        llast[cyc] = bus.m_tlast;
        lmr[cyc]   = bus.m_tready;
        lid[cyc]   = bus.m_tid;
        ldat[cyc]  = bus.m_tdata;
        lusr[cyc]  = bus.m_tuser;
        lrdy[cyc]  = bus.s_tready;
        lkeep[cyc] = bus.m_tkeep;
        hs = bus.s_tready & bus.s_tvalid;
        @(posedge ACLK);
        #1;
        for (int i = 0; i < N; i++) begin
            if (((hs >> i) & N'(1)) != '0) begin
                beat[i]++;
                if (beat[i] == plen[i]) begin
                    beat[i] = 0;
                    pkt[i]++;
                    pkts_left[i]--;
                end
            end
        end
        cyc++;
        drive();
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            pkts_left[i] = 0;
            beat[i]      = 0;
            pkt[i]       = 0;
            plen[i]      = 1;
            base[i]      = 16'(16'hA000 + i * 16'h0100);
        end
        rdy_pat = '1;
        cyc     = 0;
        drive();
    endtask

    task automatic apply_reset();
        ARESETn = 1'b0;
        clear_src();
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
    endtask

    initial begin
        int s, b, p, acc;

        // Outputs stay 0 under reset even with every source requesting.
        clear_src();
        for (int i = 0; i < N; i++) pkts_left[i] = 1;
        drive();
        #23;
        chk("rst_m_tvalid", bus.m_tvalid, 0);
        chk("rst_s_tready", bus.s_tready, 0);
        chk("rst_m_tdata",  bus.m_tdata, 0);
        chk("rst_m_tid",    bus.m_tid, 0);
        chk("rst_m_tkeep",  bus.m_tkeep, 0);
        chk("rst_m_tlast",  bus.m_tlast, 0);
        chk("rst_m_tuser",  bus.m_tuser, 0);
`ifdef AXIS_ARB_PKTCNT_EN
        chk("rst_pkt_cnt",  pkt_cnt, 0);
`endif
        apply_reset();

        // Single source, 3 beats from src1.
        base[1] = 16'h1111; pkts_left[1] = 1; plen[1] = 3;
        start();
        repeat (5) step();
        chk("t1_arb_idle_v", lv[0], 0);
        chk("t1_b0_v",    lv[1], 1);
        chk("t1_b0_data", ldat[1], 16'h1111);
        chk("t1_b0_id",   lid[1], 1);
        chk("t1_b0_rdy",  lrdy[1], 4'b0010);
        chk("t1_b0_keep", lkeep[1], 2'b11);
        chk("t1_b0_last", llast[1], 0);
        chk("t1_b1_data", ldat[2], 16'h2222);
        chk("t1_b1_id",   lid[2], 1);
        chk("t1_b2_data", ldat[3], 16'h3333);
        chk("t1_b2_last", llast[3], 1);
        chk("t1_b2_id",   lid[3], 1);
        chk("t1_end_v",   lv[4], 0);
        chk("t1_end_rdy", lrdy[4], 0);

        // ptr is now 2: src2 beats src0.
        base[1] = 16'hA100;
        pkts_left[0] = 1; pkts_left[2] = 1;
        start();
        repeat (5) step();
        chk("ptr2_idle0", lv[0], 0);
        chk("ptr2_id1",   lid[1], 2);
        chk("ptr2_v1",    lv[1], 1);
        chk("ptr2_gap",   lv[2], 0);
        chk("ptr2_id3",   lid[3], 0);
        chk("ptr2_v3",    lv[3], 1);
        chk("ptr2_end",   lv[4], 0);

        // Fairness: all four sources streaming 2-beat packets.
        apply_reset();
        for (int i = 0; i < N; i++) begin pkts_left[i] = 2; plen[i] = 2; end
        start();
        repeat (15) step();
        for (int k = 0; k < 15; k++) begin
            if (k % 3 == 0) begin
                chk($sformatf("fair_gap_v[%0d]", k), lv[k], 0);
            end else begin
                s = (k / 3) % 4; b = k % 3 - 1; p = k / 12;
                chk($sformatf("fair_v[%0d]", k),    lv[k], 1);
                chk($sformatf("fair_id[%0d]", k),   lid[k], s);
                chk($sformatf("fair_data[%0d]", k), ldat[k], src_word(s, p, b));
                chk($sformatf("fair_user[%0d]", k), lusr[k], usr_word(s, b));
                chk($sformatf("fair_last[%0d]", k), llast[k], b);
                chk($sformatf("fair_rdy[%0d]", k),  lrdy[k], 4'b0001 << s);
            end
        end

        // Wrap: src2 packet leaves ptr=3, then src0 and src3 request together.
        apply_reset();
        pkts_left[2] = 1;
        start();
        repeat (3) step();
        pkts_left[0] = 1; pkts_left[3] = 1;
        start();
        repeat (5) step();
        chk("wrap_idle0", lv[0], 0);
        chk("wrap_first_v",  lv[1], 1);
        chk("wrap_first_id", lid[1], 3);
        chk("wrap_gap",      lv[2], 0);
        chk("wrap_next_v",   lv[3], 1);
        chk("wrap_next_id",  lid[3], 0);
        chk("wrap_end",      lv[4], 0);

        // Backpressure: m_tready 1,0,0,1 across a 2-beat packet.
        apply_reset();
`ifdef AXIS_ARB_PKTCNT_EN
        cnt0 = pkt_cnt;
`endif
        pkts_left[0] = 1; plen[0] = 2;
        rdy_pat = ~32'h0000_000C;
        start();
        repeat (6) step();
        chk("bp_b0_data", ldat[1], 16'hA000);
        chk("bp_b0_last", llast[1], 0);
        for (int k = 2; k <= 4; k++) begin
            chk($sformatf("bp_v[%0d]", k),    lv[k], 1);
            chk($sformatf("bp_data[%0d]", k), ldat[k], 16'hB111);
            chk($sformatf("bp_last[%0d]", k), llast[k], 1);
            chk($sformatf("bp_id[%0d]", k),   lid[k], 0);
        end
        chk("bp_rdy_hold2", lrdy[2], 0);
        chk("bp_rdy_hold3", lrdy[3], 0);
        chk("bp_rdy_go4",   lrdy[4], 4'b0001);
        chk("bp_end_v",     lv[5], 0);
        acc = 0;
        for (int k = 0; k < 6; k++) if (lv[k] && lmr[k]) acc++;
        chk("bp_beats_accepted", acc, 2);
`ifdef AXIS_ARB_PKTCNT_EN
        chk("bp_pkt_cnt_inc", 16'(pkt_cnt - cnt0), 1);
`endif

        // Reset asserted mid-packet after beat 1 of 4.
        apply_reset();
        pkts_left[1] = 1; plen[1] = 4;
        start();
        repeat (3) step();
        #2;
        chk("mid_pre_v",  bus.m_tvalid, 1);
        chk("mid_pre_id", bus.m_tid, 1);
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_v",    bus.m_tvalid, 0);
        chk("mid_rst_rdy",  bus.s_tready, 0);
        chk("mid_rst_data", bus.m_tdata, 0);
        chk("mid_rst_id",   bus.m_tid, 0);
        chk("mid_rst_last", bus.m_tlast, 0);
        chk("mid_rst_user", bus.m_tuser, 0);
        chk("mid_rst_keep", bus.m_tkeep, 0);
        apply_reset();
        pkts_left[2] = 1;
        start();
        repeat (3) step();
        chk("post_idle0", lv[0], 0);
        chk("post_v",     lv[1], 1);
        chk("post_id",    lid[1], 2);
        chk("post_data",  ldat[1], 16'hA200);
        chk("post_end",   lv[2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-level round-robin arbiter that lets N_SRC AXI-Stream sources share one AXI-Stream master port. Typical use is feeding several message producers into one SHA3 absorb/transmit path. A grant is taken on the first beat of a packet and held until the TLAST beat is accepted, so packets are never interleaved. The granted source index is presented on the output TID so downstream logic can route digests back to the right requester.

## Interface
Parameters
- N_SRC, 4: number of source ports, 2..8
- DATA_WIDTH, 16: TDATA width in bits, multiple of 8
- USER_WIDTH, 4: TUSER width in bits
- ID_WIDTH, $clog2(N_SRC): width of m_tid

Ports
- ACLK  in  1  single clock; all logic on the rising edge
- ARESETn  in  1  asynchronous, active-low reset
- s_tvalid  in  N_SRC  per-source TVALID
- s_tready  out  N_SRC  per-source TREADY
- s_tdata  in  N_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_tlast  in  N_SRC  per-source TLAST
- s_tuser  in  N_SRC*USER_WIDTH  per-source TUSER, packed the same way as s_tdata
- m_tvalid  out  1  master TVALID
- m_tready  in  1  master TREADY
- m_tdata  out  DATA_WIDTH  muxed data
- m_tlast  out  1  muxed TLAST
- m_tuser  out  USER_WIDTH  muxed TUSER
- m_tid  out  ID_WIDTH  index of the granted source
- m_tkeep  out  DATA_WIDTH/8  all ones while m_tvalid=1, otherwise 0
- pkt_cnt  out  16  completed-packet counter; present only with AXIS_ARB_PKTCNT_EN

## Operation
- State register values: IDLE, BUSY.
- Internal registers:
  - grant, ID_WIDTH bits: current owner.
  - ptr, ID_WIDTH bits: highest-priority candidate for the next arbitration.
- IDLE:
  - All s_tready=0, m_tvalid=0.
  - If any s_tvalid=1, grant is set to the first i with s_tvalid[i]=1, searching ptr, ptr+1, … modulo N_SRC. State then moves to BUSY.
  - If no s_tvalid is set, the block stays in IDLE.
- BUSY, combinational pass-through of the granted source g:
  - m_tvalid=s_tvalid[g], m_tdata/m_tlast/m_tuser taken from source g, m_tid=g.
  - s_tready[g]=m_tready; every other s_tready is 0.
- End of packet: a beat with m_tvalid & m_tready & m_tlast in BUSY sets ptr to (g+1) mod N_SRC and returns the state to IDLE.
- ptr changes only at end of packet. Wrap: when g=N_SRC-1, ptr becomes 0.
- If the granted source drops s_tvalid mid-packet, the grant is held, m_tvalid follows s_tvalid[g], and no other source is served.
- Requests from other sources that arrive during BUSY wait. They are not lost, because AXIS sources hold TVALID until the handshake completes.

## Timing
- Reset values:
  - state=IDLE, grant=0, ptr=0, pkt_cnt=0.
  - All outputs 0: s_tready, m_tvalid, m_tdata, m_tlast, m_tuser, m_tid, m_tkeep.
- Reset is asserted asynchronously and released synchronously to ACLK (2-flop release).
- Reset asserted mid-packet: the packet is abandoned and the outputs are 0 in the same cycle. After release, arbitration restarts from ptr=0.
- Latency:
  - s_tvalid rising in IDLE at edge N gives m_tvalid=1 after edge N+1 (one arbitration cycle).
  - Data path during BUSY: zero cycles, combinational.
- Packet gap: exactly one IDLE cycle between consecutive packets, including back-to-back packets from the same source.
- Single-beat packet (TLAST on the first beat): BUSY lasts one cycle when m_tready=1.
- m_tready=0 during BUSY: all outputs hold their values and the state is unchanged.

## Configuration
- AXIS_ARB_PKTCNT_EN defined:
  - pkt_cnt exists as an output.
  - It increments by 1 on every accepted TLAST beat and wraps 0xFFFF→0x0000.
  - Reset value 0.
- AXIS_ARB_PKTCNT_EN undefined: the pkt_cnt port and the counter are absent. All other behaviour is identical.

## Test plan
- Single source: N_SRC=4, src1 sends 3 beats 0x1111, 0x2222, 0x3333 (TLAST on the 3rd), m_tready=1 → m_tvalid rises one cycle after s_tvalid[1], m_tid=1 on all beats, s_tready=0b0010, state back to IDLE, ptr=2.
- Fairness: src0..src3 each request continuously with 2-beat packets → grant order 0,1,2,3,0 with exactly one idle cycle between packets; no beat interleaving.
- Wrap and priority: ptr=3, src0 and src3 request simultaneously → src3 is granted first, then ptr=0 and src0 is served next.
- Backpressure: m_tready toggles 1,0,0,1 during a 2-beat packet → m_tdata, m_tid, m_tlast are stable while m_tready=0; no beat is dropped or duplicated; with AXIS_ARB_PKTCNT_EN, pkt_cnt increments by exactly 1.
- Reset mid-packet: ARESETn asserted after beat 1 of 4 → all outputs 0 immediately; after release, src2 requesting alone is granted with m_tid=2.
- Counter wrap (AXIS_ARB_PKTCNT_EN): pkt_cnt preloaded by traffic to 0xFFFF, one more packet → pkt_cnt=0x0000.
